// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register frame controller.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int RW_BIT = 7;
  localparam int ADDR_W = 7;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between SPI_SLAVE (master side) and the frame controller (slave side).
interface spi_reg_ctrl_if;
  logic       cs_n;
  logic [7:0] spi_dout;
  logic       spi_dout_vld;
  logic [7:0] spi_din;
  logic       spi_din_vld;
  logic       spi_ready;

  modport master (
    output cs_n, spi_dout, spi_dout_vld, spi_ready,
    input  spi_din, spi_din_vld
  );

  modport slave (
    input  cs_n, spi_dout, spi_dout_vld, spi_ready,
    output spi_din, spi_din_vld
  );
endinterface

// File: rtl/spi_reg_ctrl_sync.sv
// Two-stage synchronizer for the raw chip select plus a registered rising-edge detect.
module spi_reg_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Reset to the deasserted (high) level so reset release never looks like a frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// Parses command/data byte frames from SPI_SLAVE and executes register reads/writes.
// Define SPI_REG_CTRL_BURST_EN to stream consecutive registers within one frame.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] REG0_RST  = 8'hFF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_reg_ctrl_if.slave               spi,
  output logic [7:0]                  reg0,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic [7:0]                  err_cnt
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic cs_rise;

  spi_reg_ctrl_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (spi.cs_n),
    .rise     (cs_rise)
  );

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;
  logic [7:0]      tx_q, tx_d;
  logic            tx_pend_q, tx_pend_d;
  logic            wr_stb_q, wr_stb_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      regs_q [NUM_REGS];

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_oor;
  logic              offer;
`ifdef SPI_REG_CTRL_BURST_EN
  logic [AW-1:0]     nxt_addr;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    err_d     = err_q;
    tx_d      = tx_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_cnt_d = err_cnt_q;
    offer     = 1'b0;
    cmd_addr  = spi.spi_dout[ADDR_W-1:0];
    cmd_oor   = {1'b0, cmd_addr} >= NUM_REGS_W;
`ifdef SPI_REG_CTRL_BURST_EN
    nxt_addr  = addr_q + AW'(1);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (spi.spi_dout_vld) begin
          rd_d   = spi.spi_dout[RW_BIT];
          addr_d = cmd_addr[AW-1:0];
          err_d  = cmd_oor;
          if (cmd_oor && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (spi.spi_dout[RW_BIT]) begin
            tx_d = cmd_oor ? 8'h00 : regs_q[cmd_addr[AW-1:0]];
          end else begin
            tx_d = spi.spi_dout;
          end
          offer   = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (spi.spi_dout_vld) begin
          if (!rd_q && !err_q) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = spi.spi_dout;
          end
`ifdef SPI_REG_CTRL_BURST_EN
          addr_d = nxt_addr;
          if (rd_q) begin
            tx_d  = err_q ? 8'h00 : regs_q[nxt_addr];
            offer = 1'b1;
          end
`else
          state_d = ST_DONE;
          tx_d    = SYNC_BYTE;
          offer   = 1'b1;
`endif
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame end overrides whatever the byte path decided, but a write in flight still commits.
    if (cs_rise) begin
      state_d = ST_IDLE;
      tx_d    = SYNC_BYTE;
      offer   = 1'b1;
    end

    tx_pend_d = offer ? 1'b1 : (tx_pend_q & ~spi.spi_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      tx_q      <= SYNC_BYTE;
      tx_pend_q <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      tx_pend_q <= tx_pend_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [7:0] RST_VAL = (gi == 0) ? REG0_RST : 8'h00;
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= RST_VAL;
        end else if (wr_stb_d && wr_addr_d == AW'(gi)) begin
          regs_q[gi] <= wr_data_d;
        end
      end
    end
  endgenerate

  assign spi.spi_din     = tx_q;
  assign spi.spi_din_vld = tx_pend_q;
  assign reg0            = regs_q[0];
  assign wr_stb          = wr_stb_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign err_cnt         = err_cnt_q;
endmodule
